// File: rtl/dice_pkg.sv
// Shared definitions for the dice result tally: legal face range,
// tally FSM state encoding and the LED pip lookup.
package dice_pkg;

  localparam logic [2:0] FACE_MIN = 3'd1;
  localparam logic [2:0] FACE_MAX = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ROLLING = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_CAPTURE = 2'd3
  } tally_state_t;

  // Pip bits are {pair_mid, pair_tr_bl, pair_tl_br, centre}; non-faces light nothing.
  function automatic logic [3:0] pip_of(input logic [2:0] face);
    logic [3:0] p;
    case (face)
      3'd1:    p = 4'b0001;
      3'd2:    p = 4'b0010;
      3'd3:    p = 4'b0011;
      3'd4:    p = 4'b0110;
      3'd5:    p = 4'b0111;
      3'd6:    p = 4'b1110;
      default: p = 4'b0000;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/dice_pip_decode.sv
// Combinational face -> LED pip pattern decoder.
module dice_pip_decode
  import dice_pkg::*;
(
  input  logic [2:0] i_face,
  output logic [3:0] o_pips
);

  assign o_pips = pip_of(i_face);

endmodule

// File: rtl/dice_roll_tally.sv
// Watches the dice button, captures the settled throw once the button has
// been released long enough, and keeps saturating roll statistics.
module dice_roll_tally
  import dice_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int SUM_W  = 12,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic [2:0]       throw,
  input  logic             clear,
  input  logic [2:0]       rd_face,
  output logic             roll_valid,
  output logic [2:0]       roll_value,
  output logic [3:0]       pips,
  output logic [CNT_W-1:0] roll_count,
  output logic [CNT_W-1:0] face_count,
  output logic [SUM_W-1:0] sum,
  output logic             err
);

  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  tally_state_t     r_state;
  tally_state_t     w_state_next;
  logic [SC_W-1:0]  r_settle_cnt;
  logic [SC_W-1:0]  w_settle_next;
  logic             w_capture;
  logic             w_legal;
  logic             w_take;
  logic [3:0]       w_pips;
  logic [SUM_W:0]   w_sum_wide;

  logic             r_roll_valid;
  logic [2:0]       r_roll_value;
  logic [3:0]       r_pips;
  logic [CNT_W-1:0] r_roll_count;
  logic [SUM_W-1:0] r_sum;
  logic             r_err;
  logic [CNT_W-1:0] r_face_cnt [1:6];
  logic [CNT_W-1:0] w_face_count;

  dice_pip_decode u_pip_decode (
    .i_face (throw),
    .o_pips (w_pips)
  );

  assign w_legal    = (throw >= FACE_MIN) && (throw <= FACE_MAX);
  // A clear in the capture cycle wins, so the capture is dropped entirely.
  assign w_take     = w_capture && w_legal && !clear;
  assign w_sum_wide = {1'b0, r_sum} + {{(SUM_W-2){1'b0}}, throw};

  // FSM state and settle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
    end else begin
      r_state      <= w_state_next;
      r_settle_cnt <= w_settle_next;
    end
  end

  // Next-state logic: a re-press during settling aborts back to ROLLING.
  always_comb begin
    w_state_next  = r_state;
    w_settle_next = r_settle_cnt;
    w_capture     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (button) w_state_next = ST_ROLLING;
      end
      ST_ROLLING: begin
        if (!button) begin
          w_state_next  = ST_SETTLE;
          w_settle_next = SC_W'(SETTLE - 1);
        end
      end
      ST_SETTLE: begin
        if (button) begin
          w_state_next = ST_ROLLING;
        end else if (r_settle_cnt == '0) begin
          w_state_next = ST_CAPTURE;
        end else begin
          w_settle_next = r_settle_cnt - 1'b1;
        end
      end
      ST_CAPTURE: begin
        w_capture    = 1'b1;
        w_state_next = button ? ST_ROLLING : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Result registers, roll count, running sum and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_roll_valid <= 1'b0;
      r_roll_value <= '0;
      r_pips       <= '0;
      r_roll_count <= '0;
      r_sum        <= '0;
      r_err        <= 1'b0;
    end else begin
      r_roll_valid <= 1'b0;
      if (clear) begin
        r_roll_value <= '0;
        r_pips       <= '0;
        r_roll_count <= '0;
        r_sum        <= '0;
        r_err        <= 1'b0;
      end else if (w_capture) begin
        if (w_legal) begin
          r_roll_valid <= 1'b1;
          r_roll_value <= throw;
          r_pips       <= w_pips;
          if (r_roll_count != '1) r_roll_count <= r_roll_count + 1'b1;
          r_sum <= w_sum_wide[SUM_W] ? '1 : w_sum_wide[SUM_W-1:0];
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // One saturating histogram counter per legal face.
  generate
    for (genvar gi = 1; gi <= 6; gi++) begin : g_face
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          r_face_cnt[gi] <= '0;
        end else if (w_take && (throw == 3'(gi)) && (r_face_cnt[gi] != '1)) begin
          r_face_cnt[gi] <= r_face_cnt[gi] + 1'b1;
        end
      end
    end
  endgenerate

  // Histogram read port; non-face selects read as zero.
  always_comb begin
    w_face_count = '0;
    for (int i = 1; i <= 6; i++) begin
      if (rd_face == 3'(i)) w_face_count = r_face_cnt[i];
    end
  end

  assign roll_valid = r_roll_valid;
  assign roll_value = r_roll_value;
  assign pips       = r_pips;
  assign roll_count = r_roll_count;
  assign face_count = w_face_count;
  assign sum        = r_sum;
  assign err        = r_err;

endmodule
